rs_tag_alloc: RTL and testbench

Issue-side controller for the register rename table. It owns the pool of 4-bit reservation-station tags (1..15; tag 0 means "value valid"), grants one tag per issuing instruction, and drives the rename table's write port (new_name_index / new_name_in). It returns tags to the pool when stations release them. On a pipeline flush it walks the rename table and clears every entry back to 0.

---
 rtl/rs_tag_alloc_pkg.sv | 17 +
 rtl/rs_tag_alloc_if.sv | 30 +++
 rtl/rs_tag_alloc_prio_enc_lsb.sv | 22 ++
 rtl/rs_tag_alloc.sv | 108 ++++++++++
 tb/tb_rs_tag_alloc.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/rs_tag_alloc_pkg.sv
// Shared constants and types for the reservation-station tag allocator.
package rs_tag_alloc_pkg;

  localparam int unsigned TAG_W    = 4;
  localparam int unsigned NUM_TAGS = 15;
  localparam int unsigned NREG     = 32;
  localparam int unsigned IDX_W    = $clog2(NREG);

  // Tag 0 in the rename table means the architectural value is valid.
  localparam logic [TAG_W-1:0] TAG_VALID = '0;

  typedef enum logic {
    RUN,
    CLEAR
  } state_t;

endpackage

// File: rtl/rs_tag_alloc_if.sv
// Issue / release / rename-port bundle between the instruction handler and the tag allocator.
interface rs_tag_alloc_if #(
  parameter int unsigned TAG_W = rs_tag_alloc_pkg::TAG_W,
  parameter int unsigned IDX_W = rs_tag_alloc_pkg::IDX_W
) ();

  logic             issue_req;
  logic             issue_has_dest;
  logic [IDX_W-1:0] issue_dest;
  logic             issue_gnt;
  logic [TAG_W-1:0] issue_tag;
  logic             rel_valid;
  logic [TAG_W-1:0] rel_tag;
  logic             flush;
  logic [IDX_W-1:0] rt_index;
  logic [TAG_W-1:0] rt_name;
  logic [TAG_W-1:0] free_cnt;
  logic             busy;

  modport master (
    output issue_req, issue_has_dest, issue_dest, rel_valid, rel_tag, flush,
    input  issue_gnt, issue_tag, rt_index, rt_name, free_cnt, busy
  );

  modport slave (
    input  issue_req, issue_has_dest, issue_dest, rel_valid, rel_tag, flush,
    output issue_gnt, issue_tag, rt_index, rt_name, free_cnt, busy
  );

endinterface

// File: rtl/rs_tag_alloc_prio_enc_lsb.sv
// Lowest-set-bit encoder: bit i of the request vector maps to tag i+1.
module prio_enc_lsb #(
  parameter int unsigned N     = 15,
  parameter int unsigned TAG_W = 4
) (
  input  logic [N-1:0]     i_req,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_found
);

  always_comb begin
    o_tag   = '0;
    o_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (i_req[i] && !o_found) begin
        o_tag   = TAG_W'(i + 1);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_tag_alloc.sv
// Reservation-station tag pool: grants lowest free tag, drives the rename write port,
// reclaims released tags, and walks the rename table back to "valid" after a flush.
module rs_tag_alloc #(
  parameter int unsigned NUM_TAGS = rs_tag_alloc_pkg::NUM_TAGS,
  parameter int unsigned TAG_W    = rs_tag_alloc_pkg::TAG_W,
  parameter int unsigned NREG     = rs_tag_alloc_pkg::NREG
) (
  input logic          clk,
  input logic          rst,
  rs_tag_alloc_if.slave bus
);
  import rs_tag_alloc_pkg::*;

  localparam int unsigned IW = $clog2(NREG);

  state_t              r_state;
  logic [NUM_TAGS-1:0] r_free;
  logic [TAG_W-1:0]    r_free_cnt;
  logic [IW-1:0]       r_walk;

  logic [NUM_TAGS-1:0] w_free_nxt;
  logic [TAG_W-1:0]    w_cnt_nxt;
  logic [TAG_W-1:0]    w_enc_tag;
  logic [TAG_W-1:0]    w_enc_idx;
  logic [TAG_W-1:0]    w_rel_idx;
  logic                w_found;
  logic                w_gnt;
  logic                w_rel_ok;
  logic                w_run;

  prio_enc_lsb #(
    .N    (NUM_TAGS),
    .TAG_W(TAG_W)
  ) u_enc (
    .i_req  (r_free),
    .o_tag  (w_enc_tag),
    .o_found(w_found)
  );

  assign w_run     = ~rst & (r_state == RUN) & ~bus.flush;
  assign w_enc_idx = w_enc_tag - TAG_W'(1);
  assign w_rel_idx = bus.rel_tag - TAG_W'(1);

  assign w_gnt = w_run & bus.issue_req & (r_free_cnt != '0) & w_found;

  // Only a tag that is in range and currently allocated may come back to the pool.
  assign w_rel_ok = w_run & bus.rel_valid & (bus.rel_tag != TAG_VALID)
                  & ({1'b0, bus.rel_tag} <= (TAG_W + 1)'(NUM_TAGS))
                  & ~r_free[w_rel_idx];

  always_comb begin
    w_free_nxt = r_free;
    w_cnt_nxt  = r_free_cnt;
    if (w_gnt) begin
      w_free_nxt[w_enc_idx] = 1'b0;
      w_cnt_nxt             = w_cnt_nxt - TAG_W'(1);
    end
    if (w_rel_ok) begin
      w_free_nxt[w_rel_idx] = 1'b1;
      w_cnt_nxt             = w_cnt_nxt + TAG_W'(1);
    end
  end

  always_comb begin
    bus.issue_gnt = w_gnt;
    bus.issue_tag = w_gnt ? w_enc_tag : TAG_VALID;
    bus.rt_index  = '0;
    bus.rt_name   = TAG_VALID;
    bus.busy      = ~rst & (r_state == CLEAR);
    bus.free_cnt  = r_free_cnt;
    if (!rst) begin
      if (r_state == CLEAR) begin
        bus.rt_index = r_walk;
      end else if (w_gnt && bus.issue_has_dest && (bus.issue_dest != '0)) begin
        bus.rt_index = bus.issue_dest;
        bus.rt_name  = w_enc_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_free     <= '1;
      r_free_cnt <= TAG_W'(NUM_TAGS);
      r_walk     <= '0;
    end else if (bus.flush) begin
      r_state    <= CLEAR;
      r_free     <= '1;
      r_free_cnt <= TAG_W'(NUM_TAGS);
      r_walk     <= IW'(1);
    end else begin
      unique case (r_state)
        RUN: begin
          r_free     <= w_free_nxt;
          r_free_cnt <= w_cnt_nxt;
        end
        CLEAR: begin
          // Walk counter wraps back to 0 as the last register is written.
          r_walk <= r_walk + IW'(1);
          if (r_walk == IW'(NREG - 1)) r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_tag_alloc.sv
// Directed bench for rs_tag_alloc: allocation order, release rules, rename-port mux, flush walk.
module tb_rs_tag_alloc;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  rs_tag_alloc_if #(.TAG_W(4), .IDX_W(5)) bus ();

  rs_tag_alloc #(
    .NUM_TAGS(15),
    .TAG_W   (4),
    .NREG    (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
  endtask

  task automatic drive(input logic req, input logic hd, input logic [4:0] dest,
                       input logic rv, input logic [3:0] rtag, input logic fl);
    bus.issue_req      = req;
    bus.issue_has_dest = hd;
    bus.issue_dest     = dest;
    bus.rel_valid      = rv;
    bus.rel_tag        = rtag;
    bus.flush          = fl;
  endtask

  // Inputs change 1 time unit after a rising edge; checks happen mid-cycle.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b1, 5'd5, 1'b0, 4'd0, 1'b1);
    tick;
    #4;
    chk("rst_gnt", 32'(bus.issue_gnt), 0);
    chk("rst_tag", 32'(bus.issue_tag), 0);
    chk("rst_rt_index", 32'(bus.rt_index), 0);
    chk("rst_rt_name", 32'(bus.rt_name), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    tick;

    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0);
    #4;
    chk("post_rst_busy", 32'(bus.busy), 0);
    chk("post_rst_free_cnt", 32'(bus.free_cnt), 15);
    chk("post_rst_idle_gnt", 32'(bus.issue_gnt), 0);
    tick;

    // Drain the pool in order.
    for (int k = 1; k <= 15; k++) begin
      drive(1'b1, 1'b1, 5'd5, 1'b0, 4'd0, 1'b0);
      #4;
      chk("drain_free_cnt", 32'(bus.free_cnt), 32'(16 - k));
      chk("drain_gnt", 32'(bus.issue_gnt), 1);
      chk("drain_tag", 32'(bus.issue_tag), 32'(k));
      chk("drain_rt_index", 32'(bus.rt_index), 5);
      chk("drain_rt_name", 32'(bus.rt_name), 32'(k));
      tick;
    end
    #4;
    chk("empty_free_cnt", 32'(bus.free_cnt), 0);
    chk("empty_gnt", 32'(bus.issue_gnt), 0);
    chk("empty_tag", 32'(bus.issue_tag), 0);
    chk("empty_rt_index", 32'(bus.rt_index), 0);
    tick;

    // Release into an empty pool: no same-cycle bypass.
    drive(1'b1, 1'b1, 5'd5, 1'b1, 4'd7, 1'b0);
    #4;
    chk("nobypass_gnt", 32'(bus.issue_gnt), 0);
    tick;
    drive(1'b1, 1'b1, 5'd5, 1'b0, 4'd0, 1'b0);
    #4;
    chk("reuse_free_cnt", 32'(bus.free_cnt), 1);
    chk("reuse_gnt", 32'(bus.issue_gnt), 1);
    chk("reuse_tag", 32'(bus.issue_tag), 7);
    tick;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0);
    #4;
    chk("reuse_after_free_cnt", 32'(bus.free_cnt), 0);

    // Free tags 3,4,5 to get free_cnt=3.
    for (int t = 3; t <= 5; t++) begin
      drive(1'b0, 1'b0, 5'd0, 1'b1, 4'(t), 1'b0);
      tick;
      #4;
      chk("rel_free_cnt", 32'(bus.free_cnt), 32'(t - 2));
      #1;
    end
    tick;

    // Grant and release of tag 2 together: net zero.
    drive(1'b1, 1'b1, 5'd6, 1'b1, 4'd2, 1'b0);
    #4;
    chk("both_gnt", 32'(bus.issue_gnt), 1);
    chk("both_tag", 32'(bus.issue_tag), 3);
    tick;
    drive(1'b0, 1'b0, 5'd0, 1'b1, 4'd0, 1'b0);
    #4;
    chk("both_free_cnt", 32'(bus.free_cnt), 3);
    tick;
    drive(1'b0, 1'b0, 5'd0, 1'b1, 4'd4, 1'b0);
    #4;
    chk("rel_tag0_free_cnt", 32'(bus.free_cnt), 3);
    tick;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0);
    #4;
    chk("rel_dup_free_cnt", 32'(bus.free_cnt), 3);
    tick;

    // dest=0 allocates but never renames r0; tag 2 proves the release landed.
    drive(1'b1, 1'b1, 5'd0, 1'b0, 4'd0, 1'b0);
    #4;
    chk("dest0_gnt", 32'(bus.issue_gnt), 1);
    chk("dest0_tag", 32'(bus.issue_tag), 2);
    chk("dest0_rt_index", 32'(bus.rt_index), 0);
    chk("dest0_rt_name", 32'(bus.rt_name), 0);
    tick;
    drive(1'b1, 1'b0, 5'd9, 1'b0, 4'd0, 1'b0);
    #4;
    chk("nodest_gnt", 32'(bus.issue_gnt), 1);
    chk("nodest_tag", 32'(bus.issue_tag), 4);
    chk("nodest_rt_index", 32'(bus.rt_index), 0);
    chk("nodest_rt_name", 32'(bus.rt_name), 0);
    tick;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0);
    #4;
    chk("pre_flush_free_cnt", 32'(bus.free_cnt), 1);
    tick;

    // Flush dominates a pending issue.
    drive(1'b1, 1'b1, 5'd5, 1'b1, 4'd5, 1'b1);
    #4;
    chk("flush_gnt", 32'(bus.issue_gnt), 0);
    chk("flush_rt_index", 32'(bus.rt_index), 0);
    tick;
    for (int idx = 1; idx <= 10; idx++) begin
      drive(1'b1, 1'b1, 5'd5, 1'b1, 4'd3, (idx == 10) ? 1'b1 : 1'b0);
      #4;
      chk("walk1_busy", 32'(bus.busy), 1);
      chk("walk1_gnt", 32'(bus.issue_gnt), 0);
      chk("walk1_rt_index", 32'(bus.rt_index), 32'(idx));
      chk("walk1_rt_name", 32'(bus.rt_name), 0);
      chk("walk1_free_cnt", 32'(bus.free_cnt), 15);
      tick;
    end
    // Restarted walk; releases stay ignored throughout.
    for (int idx = 1; idx <= 31; idx++) begin
      drive(1'b1, 1'b1, 5'd5, 1'b1, 4'd3, 1'b0);
      #4;
      chk("walk2_busy", 32'(bus.busy), 1);
      chk("walk2_gnt", 32'(bus.issue_gnt), 0);
      chk("walk2_rt_index", 32'(bus.rt_index), 32'(idx));
      chk("walk2_rt_name", 32'(bus.rt_name), 0);
      tick;
    end
    drive(1'b1, 1'b1, 5'd5, 1'b0, 4'd0, 1'b0);
    #4;
    chk("resume_busy", 32'(bus.busy), 0);
    chk("resume_free_cnt", 32'(bus.free_cnt), 15);
    chk("resume_gnt", 32'(bus.issue_gnt), 1);
    chk("resume_tag", 32'(bus.issue_tag), 1);
    chk("resume_rt_index", 32'(bus.rt_index), 5);
    chk("resume_rt_name", 32'(bus.rt_name), 1);
    tick;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0);
    #4;
    chk("resume_after_free_cnt", 32'(bus.free_cnt), 14);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
